// File: rtl/timekeeper_pkg.sv
// Shared types and limits for the timekeeper clock/calendar slice.
package timekeeper_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    FS_SEC  = 2'd0,
    FS_MIN  = 2'd1,
    FS_HR   = 2'd2,
    FS_NONE = 2'd3
  } field_t;

  localparam int unsigned SEC_LIM = 60;
  localparam int unsigned MIN_LIM = 60;
  localparam int unsigned HR_LIM  = 24;

  // Converts a 0-23 hour into {pm, 12h display hour}.
  function automatic logic [5:0] to_12h(input logic [4:0] hr);
    logic [5:0] res;
    if (hr == 5'd0)
      res = {1'b0, 5'd12};
    else if (hr < 5'd12)
      res = {1'b0, hr};
    else if (hr == 5'd12)
      res = {1'b1, 5'd12};
    else
      res = {1'b1, hr - 5'd12};
    return res;
  endfunction

endpackage

// File: rtl/timekeeper_mod_counter.sv
// Modulo-LIM counter stage with synchronous clear and combinational carry-out.
module mod_counter #(
  parameter int unsigned N   = 6,
  parameter int unsigned LIM = 60
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [N-1:0] count,
  output logic         carry
);

  localparam logic [N-1:0] LAST = N'(LIM - 1);

  logic [N-1:0] r_count;

  // Count register: clear has priority over increment; wraps LAST -> 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (inc)
      r_count <= (r_count == LAST) ? '0 : r_count + N'(1);
  end

  assign count = r_count;
  assign carry = inc && (r_count == LAST);

endmodule

// File: rtl/timekeeper.sv
// Time-of-day keeper: sub-second tick, h:m:s counters, SET-mode editing,
// 12/24h display conversion and a single daily alarm.
module timekeeper
  import timekeeper_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned TICK_W        = $clog2(TICKS_PER_SEC)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run_en,
  input  logic              set_mode,
  input  logic [1:0]        field_sel,
  input  logic              inc_pulse,
  input  logic              mode_12h,
  input  logic              alarm_en,
  input  logic [4:0]        alarm_hr,
  input  logic [5:0]        alarm_min,
  input  logic              alarm_ack,
  output logic [TICK_W-1:0] tick,
  output logic [5:0]        seconds,
  output logic [5:0]        minutes,
  output logic [4:0]        hours,
  output logic [4:0]        disp_hours,
  output logic              pm,
  output logic              sec_pulse,
  output logic              alarm_ring
);

  state_t r_state;
  state_t w_next;

  field_t w_field;
  logic   w_in_run;

  logic w_tick_inc, w_tick_clear;
  logic w_edit_sec, w_edit_min, w_edit_hr;
  logic w_sec_inc, w_min_inc, w_hr_inc;
  logic w_tick_carry, w_sec_carry, w_min_carry, w_hr_carry;

  logic [TICK_W-1:0] w_tick;
  logic [5:0]        w_seconds, w_minutes, w_next_min;
  logic [4:0]        w_hours, w_next_hr;
  logic              w_alarm_hit;

  logic r_sec_pulse;
  logic r_alarm_ring;

  assign w_field  = field_t'(field_sel);
  assign w_in_run = (r_state == RUN);

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_state <= RUN;
    else
      r_state <= w_next;
  end

  // Next-state and per-stage control: RUN advances the tick, SET holds it at 0 and edits one field.
  always_comb begin
    w_next       = r_state;
    w_tick_inc   = 1'b0;
    w_tick_clear = 1'b0;
    w_edit_sec   = 1'b0;
    w_edit_min   = 1'b0;
    w_edit_hr    = 1'b0;
    case (r_state)
      RUN: begin
        if (set_mode) begin
          w_next       = SET;
          w_tick_clear = 1'b1;
        end else if (run_en) begin
          w_tick_inc = 1'b1;
        end
      end
      SET: begin
        w_tick_clear = 1'b1;
        if (!set_mode)
          w_next = RUN;
        if (inc_pulse) begin
          case (w_field)
            FS_SEC:  w_edit_sec = 1'b1;
            FS_MIN:  w_edit_min = 1'b1;
            FS_HR:   w_edit_hr  = 1'b1;
            default: ;
          endcase
        end
      end
      default: w_next = RUN;
    endcase
  end

  // Carries ripple combinationally in RUN only; SET edits never carry into the next field.
  assign w_sec_inc = (w_in_run && w_tick_carry) || w_edit_sec;
  assign w_min_inc = (w_in_run && w_sec_carry)  || w_edit_min;
  assign w_hr_inc  = (w_in_run && w_min_carry)  || w_edit_hr;

  mod_counter #(.N(TICK_W), .LIM(TICKS_PER_SEC)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_tick_clear),
    .inc     (w_tick_inc),
    .count   (w_tick),
    .carry   (w_tick_carry)
  );

  mod_counter #(.N(6), .LIM(SEC_LIM)) u_sec (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (w_sec_inc),
    .count   (w_seconds),
    .carry   (w_sec_carry)
  );

  mod_counter #(.N(6), .LIM(MIN_LIM)) u_min (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (w_min_inc),
    .count   (w_minutes),
    .carry   (w_min_carry)
  );

  mod_counter #(.N(5), .LIM(HR_LIM)) u_hr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (w_hr_inc),
    .count   (w_hours),
    .carry   (w_hr_carry)
  );

  // Post-edge minutes/hours for an advance that wraps seconds to 0.
  assign w_next_min = w_min_carry ? 6'd0 : w_minutes + 6'd1;
  assign w_next_hr  = w_hr_carry  ? 5'd0 :
                      (w_min_carry ? w_hours + 5'd1 : w_hours);

  // Out-of-range alarm settings are excluded explicitly.
  assign w_alarm_hit = alarm_en && w_in_run && w_sec_carry &&
                       (alarm_hr  < 5'(HR_LIM))  && (alarm_hr  == w_next_hr) &&
                       (alarm_min < 6'(MIN_LIM)) && (alarm_min == w_next_min);

  // One-cycle pulse aligned with the first cycle of each new second.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_sec_pulse <= 1'b0;
    else
      r_sec_pulse <= w_in_run && w_tick_carry;
  end

  // Alarm latch: disable beats everything, a new match beats acknowledge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_alarm_ring <= 1'b0;
    else if (!alarm_en)
      r_alarm_ring <= 1'b0;
    else if (w_alarm_hit)
      r_alarm_ring <= 1'b1;
    else if (alarm_ack)
      r_alarm_ring <= 1'b0;
  end

  // Display hour formatting straight from the hours counter.
  always_comb begin
    disp_hours = w_hours;
    pm         = 1'b0;
    if (mode_12h)
      {pm, disp_hours} = to_12h(w_hours);
  end

  assign tick       = w_tick;
  assign seconds    = w_seconds;
  assign minutes    = w_minutes;
  assign hours      = w_hours;
  assign sec_pulse  = r_sec_pulse;
  assign alarm_ring = r_alarm_ring;

endmodule

// File: tb/tb_timekeeper.sv
// Directed self-checking bench for timekeeper with TICKS_PER_SEC=10.
module tb_timekeeper;

  logic       clock;
  logic       reset_n;
  logic       run_en;
  logic       set_mode;
  logic [1:0] field_sel;
  logic       inc_pulse;
  logic       mode_12h;
  logic       alarm_en;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_ack;
  logic [3:0] tick;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [4:0] disp_hours;
  logic       pm;
  logic       sec_pulse;
  logic       alarm_ring;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  timekeeper #(.TICKS_PER_SEC(10), .TICK_W(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run_en     (run_en),
    .set_mode   (set_mode),
    .field_sel  (field_sel),
    .inc_pulse  (inc_pulse),
    .mode_12h   (mode_12h),
    .alarm_en   (alarm_en),
    .alarm_hr   (alarm_hr),
    .alarm_min  (alarm_min),
    .alarm_ack  (alarm_ack),
    .tick       (tick),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .disp_hours (disp_hours),
    .pm         (pm),
    .sec_pulse  (sec_pulse),
    .alarm_ring (alarm_ring)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hours"},   32'(hours),   32'(h));
    chk({tag, ".minutes"}, 32'(minutes), 32'(m));
    chk({tag, ".seconds"}, 32'(seconds), 32'(s));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // n separate one-cycle increment strobes on field f
  task automatic pulse(input logic [1:0] f, input int n);
    field_sel = f;
    repeat (n) begin
      inc_pulse = 1'b1;
      @(negedge clock);
      inc_pulse = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    run_en    = 1'b0;
    set_mode  = 1'b0;
    field_sel = 2'd0;
    inc_pulse = 1'b0;
    mode_12h  = 1'b0;
    alarm_en  = 1'b0;
    alarm_hr  = 5'd0;
    alarm_min = 6'd0;
    alarm_ack = 1'b0;

    // reset state
    cyc(2);
    chk("rst.tick", 32'(tick), 0);
    chk_time("rst", 0, 0, 0);
    chk("rst.sec_pulse", 32'(sec_pulse), 0);
    chk("rst.alarm_ring", 32'(alarm_ring), 0);
    chk("rst.disp24", 32'(disp_hours), 0);
    chk("rst.pm24", 32'(pm), 0);
    mode_12h = 1'b1;
    #1;
    chk("rst.disp12", 32'(disp_hours), 12);
    chk("rst.pm12", 32'(pm), 0);
    mode_12h = 1'b0;

    // first second after release; inc_pulse held high must be ignored in RUN
    cyc(1);
    reset_n   = 1'b1;
    run_en    = 1'b1;
    field_sel = 2'd0;
    inc_pulse = 1'b1;
    pulses    = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      pulses += int'(sec_pulse);
      if (i == 9) begin
        chk("run1.tick9", 32'(tick), 9);
        chk("run1.sec_before", 32'(seconds), 0);
      end
    end
    inc_pulse = 1'b0;
    chk("run1.seconds", 32'(seconds), 1);
    chk("run1.tick", 32'(tick), 0);
    chk("run1.sec_pulse", 32'(sec_pulse), 1);
    chk("run1.pulse_count", 32'(pulses), 1);
    cyc(1);
    chk("run1.pulse_drop", 32'(sec_pulse), 0);
    chk("run1.tick1", 32'(tick), 1);

    // asynchronous reset mid-count
    cyc(6);
    chk("mid.tick7", 32'(tick), 7);
    reset_n = 1'b0;
    #1;
    chk("mid.tick", 32'(tick), 0);
    chk_time("mid", 0, 0, 0);
    chk("mid.sec_pulse", 32'(sec_pulse), 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(9);
    chk("mid.tick9", 32'(tick), 9);
    chk("mid.sec_before", 32'(seconds), 0);
    cyc(1);
    chk("mid.seconds", 32'(seconds), 1);
    chk("mid.sec_pulse1", 32'(sec_pulse), 1);

    // run_en=0 holds everything
    cyc(3);
    chk("hold.tick3", 32'(tick), 3);
    run_en = 1'b0;
    cyc(5);
    chk("hold.tick", 32'(tick), 3);
    chk("hold.seconds", 32'(seconds), 1);

    // preload 23:59:59 in SET; tick clears on entry
    set_mode = 1'b1;
    cyc(1);
    chk("set.tick_clr", 32'(tick), 0);
    pulse(2'd0, 58);
    pulse(2'd1, 59);
    pulse(2'd2, 23);
    chk_time("preload", 23, 59, 59);
    chk("preload.tick", 32'(tick), 0);

    // full-day rollover on a single edge
    set_mode = 1'b0;
    run_en   = 1'b1;
    cyc(1);
    chk("roll.tick0", 32'(tick), 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 9) begin
        chk("roll.tick9", 32'(tick), 9);
        chk_time("roll.before", 23, 59, 59);
      end
    end
    chk_time("roll", 0, 0, 0);
    chk("roll.sec_pulse", 32'(sec_pulse), 1);
    chk("roll.tick", 32'(tick), 0);

    // SET edits wrap without carry; field 3 does nothing
    set_mode = 1'b1;
    run_en   = 1'b0;
    cyc(1);
    pulse(2'd1, 61);
    chk_time("edit.min61", 0, 1, 0);
    pulse(2'd3, 5);
    chk_time("edit.none", 0, 1, 0);
    pulse(2'd0, 60);
    chk_time("edit.sec60", 0, 1, 0);

    // 12h display
    mode_12h = 1'b1;
    #1;
    chk("h12.h0.disp", 32'(disp_hours), 12);
    chk("h12.h0.pm", 32'(pm), 0);
    pulse(2'd2, 12);
    chk("h12.h12.disp", 32'(disp_hours), 12);
    chk("h12.h12.pm", 32'(pm), 1);
    pulse(2'd2, 1);
    chk("h12.h13.disp", 32'(disp_hours), 1);
    chk("h12.h13.pm", 32'(pm), 1);
    mode_12h = 1'b0;
    #1;
    chk("h24.h13.disp", 32'(disp_hours), 13);
    chk("h24.h13.pm", 32'(pm), 0);
    pulse(2'd2, 11);
    chk_time("edit.hr_wrap", 0, 1, 0);

    // SET-mode edits landing on the alarm time must not ring
    alarm_en  = 1'b1;
    alarm_hr  = 5'd7;
    alarm_min = 6'd29;
    pulse(2'd2, 7);
    pulse(2'd1, 28);
    chk_time("alm.edit", 7, 29, 0);
    chk("alm.edit_ring", 32'(alarm_ring), 0);
    pulse(2'd0, 59);
    alarm_min = 6'd30;
    chk("alm.pre_ring", 32'(alarm_ring), 0);

    // alarm rises at 07:30:00
    set_mode = 1'b0;
    run_en   = 1'b1;
    cyc(1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 9) chk("alm.before", 32'(alarm_ring), 0);
    end
    chk("alm.rise", 32'(alarm_ring), 1);
    chk_time("alm.rise", 7, 30, 0);

    // ack alone clears
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk("alm.ack_clr", 32'(alarm_ring), 0);

    // ack in the same cycle as a new match: match wins
    alarm_min = 6'd31;
    cyc(598);
    chk("alm.pre2.tick", 32'(tick), 9);
    chk_time("alm.pre2", 7, 30, 59);
    chk("alm.pre2.ring", 32'(alarm_ring), 0);
    alarm_ack = 1'b1;
    cyc(1);
    alarm_ack = 1'b0;
    chk("alm.ack_vs_set", 32'(alarm_ring), 1);
    chk_time("alm.set2", 7, 31, 0);

    // alarm_en=0 clears
    alarm_en = 1'b0;
    cyc(1);
    chk("alm.en_clr", 32'(alarm_ring), 0);

    // out-of-range minute (60) never matches at a 07:59:59 -> 08:00:00 rollover
    set_mode = 1'b1;
    run_en   = 1'b0;
    cyc(1);
    pulse(2'd0, 59);
    pulse(2'd1, 28);
    chk_time("oor.preload", 7, 59, 59);
    alarm_en  = 1'b1;
    alarm_hr  = 5'd7;
    alarm_min = 6'd60;
    set_mode  = 1'b0;
    run_en    = 1'b1;
    cyc(11);
    chk_time("oor.roll", 8, 0, 0);
    chk("oor.sec_pulse", 32'(sec_pulse), 1);
    chk("oor.ring", 32'(alarm_ring), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
